// File: rtl/aes_pkg.sv
// Shared AES constants for the inverse key scheduler: forward S-box, round
// constants, scheduler state encoding and the AES-128 round count.
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD    = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Only entries 1..10 are meaningful; the rest pad out the 4-bit counter range.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/aes128_inv_key_sched_if.sv
// Key-load and round-key stream handshakes of the inverse key scheduler.
// The slave modport is the scheduler side, master is the key source/consumer.
interface aes128_inv_key_sched_if;

  logic         in_valid;
  logic         in_ready;
  logic [0:127] key_in;
  logic         key_is_cipher;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] rk_data;
  logic [3:0]   rk_round;
  logic         done;

  modport master (
    output in_valid, key_in, key_is_cipher, rk_ready,
    input  in_ready, rk_valid, rk_data, rk_round, done
  );

  modport slave (
    input  in_valid, key_in, key_is_cipher, rk_ready,
    output in_ready, rk_valid, rk_data, rk_round, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box lookup; four of these form the shared SubWord.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes128_inv_key_sched.sv
// Iterative AES-128 inverse key scheduler: optionally expands a cipher key up
// to round 10, then walks the schedule backwards emitting round keys 10..0.
module aes128_inv_key_sched
  import aes_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
)
(
  input  logic                   clk,
  input  logic                   rst,
  aes128_inv_key_sched_if.slave  bus
);

  state_t       state, state_nxt;
  logic [0:127] kreg, kreg_nxt;
  logic [3:0]   rc, rc_nxt;
  logic         done_q, done_nxt;

  logic [0:31]  k0, k1, k2, k3;
  logic [0:31]  p0, p1, p2, p3;
  logic [0:31]  n0, n1, n2, n3;
  logic [0:31]  sub_in, rot, sub_out, t;
  logic         in_ready_int;

  assign k0 = kreg[0:31];
  assign k1 = kreg[32:63];
  assign k2 = kreg[64:95];
  assign k3 = kreg[96:127];

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // One SubWord serves both directions: forward rounds rotate k3, inverse
  // steps rotate the recovered previous-round w3.
  assign sub_in = (state == FWD) ? k3 : p3;
  assign rot    = {sub_in[8:31], sub_in[0:7]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot[8*i +: 8]),
      .out_byte (sub_out[8*i +: 8])
    );
  end

  assign t  = sub_out ^ {RCON[rc], 24'h000000};

  assign n0 = k0 ^ t;
  assign n1 = k1 ^ n0;
  assign n2 = k2 ^ n1;
  assign n3 = k3 ^ n2;

  assign p0 = k0 ^ t;

  // The done cycle is kept out of in_ready so a new key lands after it.
  assign in_ready_int  = (state == IDLE) && !done_q && !rst;
  assign bus.in_ready  = in_ready_int;
  assign bus.rk_valid  = (state == STREAM);
  assign bus.rk_data   = (state == STREAM) ? kreg : '0;
  assign bus.rk_round  = (state == STREAM) ? rc : '0;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      kreg   <= '0;
      rc     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      kreg   <= kreg_nxt;
      rc     <= rc_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    kreg_nxt  = kreg;
    rc_nxt    = rc;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_int) begin
          kreg_nxt = bus.key_in;
          if (FWD_EN && bus.key_is_cipher) begin
            rc_nxt    = 4'd1;
            state_nxt = FWD;
          end else begin
            rc_nxt    = NR;
            state_nxt = STREAM;
          end
        end
      end
      FWD: begin
        kreg_nxt = {n0, n1, n2, n3};
        if (rc == NR) begin
          state_nxt = STREAM;
        end else begin
          rc_nxt = rc + 4'd1;
        end
      end
      STREAM: begin
        if (bus.rk_ready) begin
          if (rc != 4'd0) begin
            kreg_nxt = {p0, p1, p2, p3};
            rc_nxt   = rc - 4'd1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Self-checking bench for the inverse key scheduler: known-answer round keys
// queued as a scoreboard and checked on each presented round key.
module tb_aes128_inv_key_sched;

  typedef struct packed {
    logic [3:0]   round;
    logic [127:0] data;
    logic         known;
  } exp_t;

  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  aes128_inv_key_sched_if bus ();

  aes128_inv_key_sched #(.FWD_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic push_fips();
    for (int r = 10; r >= 0; r--) begin
      sb_q.push_back('{round: 4'(r), data: FIPS_RK[r], known: 1'b1});
    end
  endtask

  // Zero-key schedule: only rounds 10, 1 and 0 carry a known value.
  task automatic push_zero();
    for (int r = 10; r >= 0; r--) begin
      exp_t e;
      e.round = 4'(r);
      e.known = (r == 10 || r == 1 || r == 0);
      e.data  = (r == 10) ? 128'hb4ef5bcb3e92e21123e951cf6f8f188e :
                (r == 1)  ? 128'h62636363626363636263636362636363 : 128'h0;
      sb_q.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input logic [127:0] key, input logic is_cipher);
    bus.in_valid      = 1'b1;
    bus.key_in        = key;
    bus.key_is_cipher = is_cipher;
    check_output("load_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Entered one cycle after key acceptance; consumes the whole scoreboard.
  task automatic run_stream(input int exp_lat, input bit random_ready, input int inject_at);
    int cyc = 1;
    bit seen = 1'b0;
    while (sb_q.size() > 0 && cyc < 300) begin
      bus.rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == inject_at) begin
        bus.in_valid = 1'b1;
        bus.key_in   = 128'h0123456789abcdeffedcba9876543210;
        check_output("busy_in_ready", 128'(bus.in_ready), 128'd0);
      end
      check_output("stream_done_low", 128'(bus.done), 128'd0);
      if (bus.rk_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check_output("first_valid_latency", 128'(cyc), 128'(exp_lat));
        end
        check_output("rk_round", 128'(bus.rk_round), 128'(sb_q[0].round));
        if (sb_q[0].known) check_output("rk_data", bus.rk_data, sb_q[0].data);
        if (bus.rk_ready) void'(sb_q.pop_front());
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cyc++;
    end
    check_output("stream_complete", 128'(sb_q.size()), 128'd0);
    sb_q.delete();
    bus.rk_ready = 1'b0;
    check_output("done_pulse", 128'(bus.done), 128'd1);
    check_output("valid_drop", 128'(bus.rk_valid), 128'd0);
    check_output("done_in_ready", 128'(bus.in_ready), 128'd0);
    @(posedge clk); #1;
    check_output("done_clear", 128'(bus.done), 128'd0);
    check_output("idle_in_ready", 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.key_in        = '0;
    bus.key_is_cipher = 1'b0;
    bus.rk_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 128'(bus.in_ready), 128'd0);
    check_output("rst_rk_valid", 128'(bus.rk_valid), 128'd0);
    check_output("rst_rk_data", bus.rk_data, 128'd0);
    check_output("rst_rk_round", 128'(bus.rk_round), 128'd0);
    check_output("rst_done", 128'(bus.done), 128'd0);
    rst = 1'b0;
    #1;
    check_output("post_rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;

    // Cipher key, forward pass then full descent.
    push_fips();
    apply_stimulus(FIPS_RK[0], 1'b1);
    run_stream(11, 1'b0, 0);

    // Round-10 key with a stray load attempt mid-stream.
    push_fips();
    apply_stimulus(FIPS_RK[10], 1'b0);
    run_stream(1, 1'b0, 4);

    // Random back-pressure.
    push_fips();
    apply_stimulus(FIPS_RK[10], 1'b0);
    run_stream(1, 1'b1, 0);

    // Reset while round 5 is presented.
    apply_stimulus(FIPS_RK[10], 1'b0);
    bus.rk_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("pre_rst_round", 128'(bus.rk_round), 128'd5);
    check_output("pre_rst_data", bus.rk_data, FIPS_RK[5]);
    rst = 1'b1;
    #1;
    bus.rk_ready = 1'b0;
    check_output("mid_rst_rk_valid", 128'(bus.rk_valid), 128'd0);
    check_output("mid_rst_rk_data", bus.rk_data, 128'd0);
    check_output("mid_rst_rk_round", 128'(bus.rk_round), 128'd0);
    check_output("mid_rst_in_ready", 128'(bus.in_ready), 128'd0);
    check_output("mid_rst_done", 128'(bus.done), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("after_rst_done", 128'(bus.done), 128'd0);
    check_output("after_rst_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    push_fips();
    apply_stimulus(FIPS_RK[10], 1'b0);
    run_stream(1, 1'b0, 0);

    // All-zero cipher key.
    push_zero();
    apply_stimulus(128'h0, 1'b1);
    run_stream(11, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
